// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Instruction fetch controller. It drives a combinational instruction ROM from
// a byte program counter and captures the returned words, each tagged with its
// PC, in a 2-entry buffer. Decode pops the buffer with a valid/ready handshake.
// The controller also handles branch/jump redirects, a level-sensitive halt,
// and an optional fetch range check.
//
// Parameters
//   DATA_WIDTH  instruction word width
//   ADDR_WIDTH  ROM word-address width
//   RESET_PC    byte address of the first fetch after reset
//
// Ports
//   clk             single clock, all state updates on the rising edge
//   rst             synchronous active-high reset
//   rom_addr        word address to the ROM, pc[ADDR_WIDTH+1:2]
//   rom_data        ROM read data for rom_addr (combinational)
//   inst_valid      head-of-buffer instruction is valid
//   inst_ready      decode accepts the head instruction
//   inst            head instruction (0 when not valid)
//   inst_pc         byte PC of the head instruction (0 when not valid)
//   redirect_valid  redirect request; flushes the buffer and reloads pc
//   redirect_pc     redirect target (bits [1:0] are ignored)
//   halt            level request to suspend fetching
//   fetch_fault     sticky out-of-range fetch flag
//
// Configuration
//   IMEM_RANGE_CHECK_EN  when defined, a fetch from beyond ROM word 512 is
//                        suppressed. It raises fetch_fault and parks the
//                        controller in FAULT until reset. When undefined,
//                        fetch_fault is tied to 0 and FAULT is unreachable.
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [31:0]           inst_pc,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  input  logic                  halt,
  output logic                  fetch_fault
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [31:0]           pc_reg, pc_next;
  logic [1:0]            count_reg, count_next;

  // Buffer entry 0 is always the head; entry 1 shifts down on a pop.
  logic [31:0]           epc_reg  [2];
  logic [31:0]           epc_next [2];
  logic [DATA_WIDTH-1:0] ewd_reg  [2];
  logic [DATA_WIDTH-1:0] ewd_next [2];

  logic                  redir;
  logic                  pop;
  logic                  push_cond;
  logic                  out_of_range;
  logic                  fault_trig;
  logic                  push;
  logic [1:0]            fill;

  // The low two bits of a redirect target are forced to zero.
  logic                  unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign rom_addr   = pc_reg[ADDR_WIDTH+1:2];
  assign inst_valid = (count_reg != 2'd0);
  assign inst       = inst_valid ? ewd_reg[0] : '0;
  assign inst_pc    = inst_valid ? epc_reg[0] : 32'h0;

  // A redirect is dead while faulted. A live redirect wins over pop, push and
  // halt.
  assign redir = redirect_valid && (state_reg != FAULT);
  assign pop   = inst_valid && inst_ready && !redir;

  // A fetch may land in the same cycle a full buffer is drained by one entry.
  assign push_cond = (state_reg == RUN) && !halt && !redirect_valid &&
                     ((count_reg != 2'd2) || pop);

`ifdef IMEM_RANGE_CHECK_EN
  logic fault_reg;

  // The ROM holds words 0..512, so any word index above 512 is out of range.
  assign out_of_range = (pc_reg[31:2] > 30'd512);
  assign fetch_fault  = fault_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_reg <= 1'b0;
    end else if (fault_trig) begin
      fault_reg <= 1'b1;
    end
  end
`else
  assign out_of_range = 1'b0;
  assign fetch_fault  = 1'b0;
`endif

  assign fault_trig = push_cond && out_of_range;
  assign push       = push_cond && !out_of_range;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        if (fault_trig) begin
          state_next = FAULT;
        end else if (halt) begin
          state_next = STALL;
        end
      end
      STALL: begin
        if (!halt) begin
          state_next = RUN;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Program counter. It wraps modulo 2^32 through plain 32-bit addition.
  always_comb begin
    pc_next = pc_reg;
    if (redir) begin
      pc_next = {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      pc_next = pc_reg + 32'd4;
    end
  end

  // Buffer update. A pop shifts first, then a push writes the first free
  // slot, so a simultaneous push and pop keeps the count unchanged.
  always_comb begin
    count_next = count_reg;
    fill       = count_reg;
    for (int i = 0; i < 2; i++) begin
      epc_next[i] = epc_reg[i];
      ewd_next[i] = ewd_reg[i];
    end
    if (redir) begin
      count_next = 2'd0;
    end else begin
      if (pop) begin
        epc_next[0] = epc_reg[1];
        ewd_next[0] = ewd_reg[1];
        fill        = count_reg - 2'd1;
      end
      if (push) begin
        epc_next[fill[0]] = pc_reg;
        ewd_next[fill[0]] = rom_data;
      end
      count_next = count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      count_reg <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        epc_reg[i] <= 32'h0;
        ewd_reg[i] <= '0;
      end
    end else begin
      pc_reg    <= pc_next;
      count_reg <= count_next;
      for (int i = 0; i < 2; i++) begin
        epc_reg[i] <= epc_next[i];
        ewd_reg[i] <= ewd_next[i];
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//
// Directed bench for imem_fetch_ctrl.
//
// The ROM is modelled as word 0 = 32'h2001_0005 and every other word =
// 32'hC000_0000 | word_address. For example, word 64 is 32'hC000_0040 and
// word 512 is 32'hC000_0200.
//
// Outputs are sampled 1 ns after each rising edge. Inputs for the next edge
// are driven right after sampling.
// -----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rom_data = (rom_addr == 10'd0) ? 32'h2001_0005 : {22'h300000, rom_addr};

  imem_fetch_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (10),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .fetch_fault    (fetch_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;

    // Reset, held for three cycles
    repeat (3) tick();
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_fault", {31'b0, fetch_fault}, 32'd0);
    check("rst_romaddr", {22'b0, rom_addr}, 32'd0);
    rst = 1'b0;

    // The first fetch happens in the first cycle after reset is released
    tick();
    check("first_valid", {31'b0, inst_valid}, 32'd1);
    check("first_inst", inst, 32'h2001_0005);
    check("first_pc", inst_pc, 32'h0);
    tick();
    check("stream_pc4", inst_pc, 32'h4);
    check("stream_inst4", inst, 32'hC000_0001);
    tick();
    check("stream_pc8", inst_pc, 32'h8);

    // Backpressure: restart at 0, then hold ready low for five cycles
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    check("bp_flush", {31'b0, inst_valid}, 32'd0);
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    repeat (5) tick();
    check("bp_head_held", inst_pc, 32'h0);
    check("bp_valid", {31'b0, inst_valid}, 32'd1);
    check("bp_pc_stop", {22'b0, rom_addr}, 32'd2);
    inst_ready = 1'b1;
    tick();
    check("bp_rel_pc4", inst_pc, 32'h4);
    tick();
    check("bp_rel_pc8", inst_pc, 32'h8);

    // Redirect while the buffer is full (count = 2)
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    check("rd_flush", {31'b0, inst_valid}, 32'd0);
    check("rd_romaddr", {22'b0, rom_addr}, 32'd64);
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    tick();
    check("rd_valid", {31'b0, inst_valid}, 32'd1);
    check("rd_pc", inst_pc, 32'h0000_0100);
    check("rd_inst", inst, 32'hC000_0040);

    // Halt for four cycles: the buffer drains and the pc is held
    halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("halt_valid%0d", i), {31'b0, inst_valid}, 32'd0);
      check($sformatf("halt_romaddr%0d", i), {22'b0, rom_addr}, 32'd65);
    end
    halt = 1'b0;
    tick();
    check("resume_gap", {31'b0, inst_valid}, 32'd0);
    tick();
    check("resume_valid", {31'b0, inst_valid}, 32'd1);
    check("resume_pc", inst_pc, 32'h0000_0104);

    // Redirect in the same cycle as a pop
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    check("rp_flush", {31'b0, inst_valid}, 32'd0);
    redirect_valid = 1'b0;
    tick();
    check("rp_pc0", inst_pc, 32'h0000_0200);
    tick();
    check("rp_pc1", inst_pc, 32'h0000_0204);

    // Range boundary: word 512 is legal, word 513 is not
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0800;
    tick();
    check("rng_flush", {31'b0, inst_valid}, 32'd0);
    redirect_valid = 1'b0;
    tick();
    check("rng_pc512", inst_pc, 32'h0000_0800);
    check("rng_inst512", inst, 32'hC000_0200);
    tick();
`ifdef IMEM_RANGE_CHECK_EN
    check("rng_fault", {31'b0, fetch_fault}, 32'd1);
    check("rng_nopush", {31'b0, inst_valid}, 32'd0);
    // A redirect issued while faulted must be ignored
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("rng_fault_hold", {31'b0, fetch_fault}, 32'd1);
    check("rng_fault_novalid", {31'b0, inst_valid}, 32'd0);
`else
    check("rng_nofault", {31'b0, fetch_fault}, 32'd0);
    check("rng_pc513", inst_pc, 32'h0000_0804);
    tick();
    check("rng_pc514", inst_pc, 32'h0000_0808);
`endif

    // Reset again in mid-run
    rst = 1'b1;
    tick();
    check("rst2_valid", {31'b0, inst_valid}, 32'd0);
    check("rst2_fault", {31'b0, fetch_fault}, 32'd0);
    check("rst2_pc", inst_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
